// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares one register-file write port between two write-back
//            requesters (port 0 = load results, port 1 = ALU results).
//            Each requester has a DEPTH-entry FIFO behind valid/ready.
//            One FIFO head is granted per cycle and drives the registered
//            we/waddr/wdata outputs. Pending flags for two query addresses
//            let decode stall on writes still queued or staged.
// Ports    : clk, rst (sync, active-high)
//            reqN_valid/reqN_ready/reqN_addr/reqN_data - requester N
//            we/waddr/wdata   - registered register-file write port
//            qaddr1/qaddr2    - decode query addresses
//            pend1/pend2      - write to qaddrN queued or staged (comb)
// Options  : WB_ARB_RR_EN defined   -> round-robin on contention
//            WB_ARB_RR_EN undefined -> fixed priority, port 0 wins
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] qaddr1,
    input  logic [ADDR_W-1:0] qaddr2,
    output logic              pend1,
    output logic              pend2
);

    localparam int              c_PW   = $clog2(DEPTH);
    localparam logic [c_PW:0]   c_FULL = (c_PW+1)'(DEPTH);

    // Per-port FIFO state, indexed by port number
    logic [ADDR_W-1:0] r_fa   [2][DEPTH];
    logic [DATA_W-1:0] r_fd   [2][DEPTH];
    logic [c_PW-1:0]   r_wptr [2];
    logic [c_PW-1:0]   r_rptr [2];
    logic [c_PW:0]     r_cnt  [2];
    logic [1:0]        r_ready;

    logic [1:0]        w_vld;
    logic [ADDR_W-1:0] w_in_addr [2];
    logic [DATA_W-1:0] w_in_data [2];
    logic [ADDR_W-1:0] w_q       [2];
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_ne;
    logic [1:0]        w_pend;
    logic [c_PW:0]     w_cnt_nxt [2];

    assign w_vld        = {req1_valid, req0_valid};
    assign w_in_addr[0] = req0_addr;
    assign w_in_addr[1] = req1_addr;
    assign w_in_data[0] = req0_data;
    assign w_in_data[1] = req1_data;
    assign w_q[0]       = qaddr1;
    assign w_q[1]       = qaddr2;
    assign req0_ready   = r_ready[0];
    assign req1_ready   = r_ready[1];
    assign pend1        = w_pend[0];
    assign pend2        = w_pend[1];

`ifdef WB_ARB_RR_EN
    // 1 = port 1 was granted most recently; reset favours port 0
    logic r_last1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last1 <= 1'b1;
        end else if (w_pop != 2'b00) begin
            r_last1 <= w_pop[1];
        end
    end
`endif

    // Arbitration, handshake and next-count
    always_comb begin
        w_ne[0] = (r_cnt[0] != '0);
        w_ne[1] = (r_cnt[1] != '0);
`ifdef WB_ARB_RR_EN
        w_pop[1] = w_ne[1] & (~w_ne[0] | ~r_last1);
`else
        w_pop[1] = w_ne[1] & ~w_ne[0];
`endif
        w_pop[0] = w_ne[0] & ~w_pop[1];
        for (int p = 0; p < 2; p++) begin
            // Address-0 writes complete the handshake but are discarded
            w_push[p]    = w_vld[p] & r_ready[p] & (w_in_addr[p] != '0);
            w_cnt_nxt[p] = r_cnt[p] + (c_PW+1)'(w_push[p]) - (c_PW+1)'(w_pop[p]);
        end
    end

    // FIFO storage (no reset needed; validity is tracked by the counts)
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
                r_fa[p][r_wptr[p]] <= w_in_addr[p];
                r_fd[p][r_wptr[p]] <= w_in_data[p];
            end
        end
    end

    // FIFO control and register-file write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_wptr[p] <= '0;
                r_rptr[p] <= '0;
                r_cnt[p]  <= '0;
            end
            r_ready <= 2'b00;
            we      <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_push[p]) r_wptr[p] <= r_wptr[p] + c_PW'(1);
                if (w_pop[p])  r_rptr[p] <= r_rptr[p] + c_PW'(1);
                r_cnt[p]   <= w_cnt_nxt[p];
                // Ready follows the post-edge count only, so a full FIFO
                // that pops this cycle still shows not-ready
                r_ready[p] <= (w_cnt_nxt[p] != c_FULL);
            end
            we <= |w_pop;
            if (w_pop[0]) begin
                waddr <= r_fa[0][r_rptr[0]];
                wdata <= r_fd[0][r_rptr[0]];
            end else if (w_pop[1]) begin
                waddr <= r_fa[1][r_rptr[1]];
                wdata <= r_fd[1][r_rptr[1]];
            end
        end
    end

    // Pending check: slot i is live when its distance from the read pointer
    // (mod DEPTH) is below the count
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            w_pend[q] = we && (waddr == w_q[q]);
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (({1'b0, c_PW'(i) - r_rptr[p]} < r_cnt[p]) &&
                        (r_fa[p][i] == w_q[q])) begin
                        w_pend[q] = 1'b1;
                    end
                end
            end
            if (w_q[q] == '0) w_pend[q] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Self-checking bench for wb_port_arbiter. A queue-based model
//            tracks the two requester FIFOs; every write the model grants is
//            pushed to a scoreboard and a negedge monitor pops and compares
//            it when the DUT asserts we. Ready and pending flags are
//            compared every cycle. Honours WB_ARB_RR_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] qaddr1, qaddr2;
    logic              pend1, pend2;

    wb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .we(we), .waddr(waddr), .wdata(wdata),
        .qaddr1(qaddr1), .qaddr2(qaddr2), .pend1(pend1), .pend2(pend2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    // Reference model state
    ent_t              mq0[$], mq1[$], sb[$];
    bit                m_init = 0;
    bit                m_we, m_rdy0, m_rdy1, m_last, m_hs0, m_hs1;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc_no, got, exp);
        end
    endtask

    function automatic bit m_pend(logic [ADDR_W-1:0] q);
        if (q == '0) return 1'b0;
        if (m_we && m_waddr == q) return 1'b1;
        foreach (mq0[i]) if (mq0[i].a == q) return 1'b1;
        foreach (mq1[i]) if (mq1[i].a == q) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model across one rising edge using the inputs held there
    task automatic model_edge();
        ent_t e;
        int   g;
        if (rst) begin
            mq0.delete(); mq1.delete();
            m_we = 0; m_waddr = '0; m_wdata = '0;
            m_rdy0 = 0; m_rdy1 = 0; m_last = 1; m_hs0 = 0; m_hs1 = 0;
            m_init = 1;
            return;
        end
        m_hs0 = req0_valid && m_rdy0;
        m_hs1 = req1_valid && m_rdy1;
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) begin
`ifdef WB_ARB_RR_EN
            g = m_last ? 0 : 1;
`else
            g = 0;
`endif
        end else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
        m_we = (g >= 0);
        if (g == 0) e = mq0.pop_front();
        else if (g == 1) e = mq1.pop_front();
        if (g >= 0) begin
            m_waddr = e.a;
            m_wdata = e.d;
            sb.push_back(e);
            m_last = (g == 1);
        end
        if (m_hs0 && req0_addr != '0) begin
            e.a = req0_addr; e.d = req0_data; mq0.push_back(e);
        end
        if (m_hs1 && req1_addr != '0) begin
            e.a = req1_addr; e.d = req1_data; mq1.push_back(e);
        end
        m_rdy0 = (mq0.size() != DEPTH);
        m_rdy1 = (mq1.size() != DEPTH);
    endtask

    // Monitor: compares DUT outputs against model/scoreboard each cycle
    ent_t mon_e;
    always @(negedge clk) begin
        if (m_init) begin
            chk("we", 32'(we), 32'(m_we));
            chk("waddr_reg", 32'(waddr), 32'(m_waddr));
            if (we === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'(waddr), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_waddr", 32'(waddr), 32'(mon_e.a));
                    chk("sb_wdata", wdata, mon_e.d);
                end
            end
            chk("req0_ready", 32'(req0_ready), 32'(m_rdy0));
            chk("req1_ready", 32'(req1_ready), 32'(m_rdy1));
            chk("pend1", 32'(pend1), 32'(m_pend(qaddr1)));
            chk("pend2", 32'(pend2), 32'(m_pend(qaddr2)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        cyc_no++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        int k;
        int pv0, pv1;
        rst = 1; idle();
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        qaddr1 = '0; qaddr2 = '0;
        cyc(); cyc();
        rst = 0;
        cyc();

        // Single write on port 1, watch its pending flag
        qaddr1 = 5'd5; qaddr2 = 5'd0;
        req1_valid = 1; req1_addr = 5'd5; req1_data = 32'h1234_5678;
        cyc();
        idle();
        repeat (5) cyc();

        // Write to register 0 is swallowed
        req0_valid = 1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
        qaddr1 = 5'd0; qaddr2 = 5'd0;
        cyc();
        idle();
        repeat (4) cyc();

        // Contention: p0 10,11 and p1 20,21 pushed together
        qaddr1 = 5'd11; qaddr2 = 5'd21;
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1; req0_addr = 5'(10 + i); req0_data = 32'hA000 + 32'(i);
            req1_valid = 1; req1_addr = 5'(20 + i); req1_data = 32'hB000 + 32'(i);
            cyc();
        end
        idle();
        repeat (6) cyc();

        // Backpressure: port 0 streams while port 1 offers addrs 1,2,3
        k = 0;
        qaddr1 = 5'd3; qaddr2 = 5'd2;
        for (int c = 0; c < 40 && k < 3; c++) begin
            req0_valid = (c < 10); req0_addr = 5'(c % 7 + 8); req0_data = $urandom;
            req1_valid = 1; req1_addr = 5'(k + 1); req1_data = 32'hC0 + 32'(k);
            cyc();
            if (m_hs1) k++;
        end
        chk("bp_accepted", 32'(k), 32'd3);
        idle();
        repeat (6) cyc();

        // Reset with writes queued on both ports
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_addr = 5'(4 + i); req0_data = $urandom;
            req1_valid = 1; req1_addr = 5'(12 + i); req1_data = $urandom;
            cyc();
        end
        idle();
        qaddr1 = 5'd5; qaddr2 = 5'd13;
        rst = 1; cyc(); rst = 0;
        repeat (5) cyc();

        // Randomised phases with varying load and occasional reset
        for (int ph = 0; ph < 8; ph++) begin
            pv0 = $urandom_range(10, 100);
            pv1 = $urandom_range(10, 100);
            for (int c = 0; c < 400; c++) begin
                rst        = ($urandom_range(0, 299) == 0);
                req0_valid = ($urandom_range(1, 100) <= pv0);
                req1_valid = ($urandom_range(1, 100) <= pv1);
                req0_addr  = 5'($urandom_range(0, 7));
                req1_addr  = 5'($urandom_range(0, 7));
                req0_data  = $urandom;
                req1_data  = $urandom;
                qaddr1     = 5'($urandom_range(0, 7));
                qaddr2     = 5'($urandom_range(0, 7));
                cyc();
            end
        end

        // Drain and confirm every granted write was observed
        rst = 0; idle();
        repeat (10) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("fifo0_drained", 32'(mq0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
